// File: rtl/anton_neopixel_pkg.sv
// anton_neopixel_pkg
//   Shared definitions for the NeoPixel stream encoder: FSM state type,
//   default WS2812 timing at a 20 MHz bus clock, buffer size default and
//   a counter-width helper.
//   No ports (package).
package anton_neopixel_pkg;

  localparam int BUFFER_END_DEFAULT  = 255;

  localparam int CYCLES_BIT_DEFAULT   = 25;    // 1.25 us per data bit
  localparam int CYCLES_T0H_DEFAULT   = 8;     // 0.40 us high for a 0
  localparam int CYCLES_T1H_DEFAULT   = 16;    // 0.80 us high for a 1
  localparam int CYCLES_RESET_DEFAULT = 1000;  // 50 us latch

  // Byte addresses are compared at this width so that a clamped limit
  // plus the 32-bit skip can never wrap back below the limit.
  localparam int ADDR_CMP_BITS = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } neo_state_t;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_encoder.sv
// anton_neopixel_bit_encoder
//   Produces one WS2812 data bit: a high phase of CYCLES_T1H (bit=1) or
//   CYCLES_T0H (bit=0) clocks followed by a low phase that pads the bit to
//   exactly CYCLES_BIT clocks. A new bit may be started in the same cycle
//   that bitDone is reported, so consecutive bits have no gap.
//   Ports:
//     busClk, busReset : clock, synchronous active-high reset
//     bitValue         : value of the bit to send, sampled when start=1
//     start            : begin a new bit on the next edge
//     neoData          : registered data line (1 only in the high phase)
//     highDone         : last clock of the high phase
//     bitDone          : last clock of the low phase (bit complete)
module anton_neopixel_bit_encoder
  import anton_neopixel_pkg::*;
#(
  parameter int CYCLES_BIT = CYCLES_BIT_DEFAULT,
  parameter int CYCLES_T0H = CYCLES_T0H_DEFAULT,
  parameter int CYCLES_T1H = CYCLES_T1H_DEFAULT
) (
  input  logic busClk,
  input  logic busReset,
  input  logic bitValue,
  input  logic start,
  output logic neoData,
  output logic highDone,
  output logic bitDone
);

  localparam int CW = cnt_bits(CYCLES_BIT);

  localparam logic [CW-1:0] HIGH0_LOAD = CW'(CYCLES_T0H - 1);
  localparam logic [CW-1:0] HIGH1_LOAD = CW'(CYCLES_T1H - 1);
  localparam logic [CW-1:0] LOW0_LOAD  = CW'(CYCLES_BIT - CYCLES_T0H - 1);
  localparam logic [CW-1:0] LOW1_LOAD  = CW'(CYCLES_BIT - CYCLES_T1H - 1);

  logic          high_q;
  logic          active_q;
  logic          bit_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge busClk) begin
    if (busReset) begin
      high_q   <= 1'b0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      high_q   <= 1'b1;
      active_q <= 1'b1;
      bit_q    <= bitValue;
      cnt_q    <= bitValue ? HIGH1_LOAD : HIGH0_LOAD;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        if (high_q) begin
          high_q <= 1'b0;
          cnt_q  <= bit_q ? LOW1_LOAD : LOW0_LOAD;
        end else begin
          active_q <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign neoData  = high_q;
  assign highDone = active_q &  high_q & (cnt_q == '0);
  assign bitDone  = active_q & ~high_q & (cnt_q == '0);

endmodule

// File: rtl/anton_neopixel_stream.sv
// anton_neopixel_stream
//   WS2812 serial encoder behind the NeoPixel register block. Walks the
//   front pixel buffer byte by byte (MSB first), drives the single-wire
//   waveform, appends the low latch period and pulses stream_sync_of on
//   its final clock so the register block can clear or keep the run bit.
//   Ports:
//     busClk, busReset : clock, synchronous active-high reset
//     pixelAddr        : byte index into the front buffer
//     pixelData        : buffer byte at pixelAddr (combinational read)
//     reg_max          : last byte index when reg_ctrl_limit=1
//     reg_ctrl_limit   : clamp the frame to min(reg_max, BUFFER_END)
//     reg_ctrl_run     : frame request, sampled in IDLE only
//     reg_ctrl_32bit   : 4-byte pixel slots, byte 3 of each slot skipped
//     neoData          : NeoPixel data line
//     stream_sync_of   : one-clock pulse on the last latch clock
//     state            : busy flag, 1 from frame start to end of latch
//
//   state | meaning
//   IDLE  | line low, waiting for reg_ctrl_run
//   HIGH  | high phase of the current bit
//   LOW   | low phase of the current bit; next byte fetched here
//   LATCH | line low for CYCLES_RESET clocks, sync on the last one
module anton_neopixel_stream
  import anton_neopixel_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int CYCLES_BIT   = CYCLES_BIT_DEFAULT,
  parameter int CYCLES_T0H   = CYCLES_T0H_DEFAULT,
  parameter int CYCLES_T1H   = CYCLES_T1H_DEFAULT,
  parameter int CYCLES_RESET = CYCLES_RESET_DEFAULT,
  localparam int BUFFER_BITS = cnt_bits(BUFFER_END + 1)
) (
  input  logic                   busClk,
  input  logic                   busReset,
  output logic [BUFFER_BITS-1:0] pixelAddr,
  input  logic [7:0]             pixelData,
  input  logic [12:0]            reg_max,
  input  logic                   reg_ctrl_limit,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_32bit,
  output logic                   neoData,
  output logic                   stream_sync_of,
  output logic                   state
);

  localparam int AW = ADDR_CMP_BITS;
  localparam int LW = cnt_bits(CYCLES_RESET);
  localparam logic [AW-1:0] BUF_END = AW'(BUFFER_END);

  neo_state_t             state_q, state_n;
  logic [BUFFER_BITS-1:0] addr_q;
  logic [AW-1:0]          last_q;
  logic                   mode32_q;
  logic [6:0]             shift_q;    // remaining bits of the current byte
  logic [2:0]             bit_idx_q;  // index of the bit being sent
  logic                   last_byte_q;
  logic [LW-1:0]          latch_q, latch_n;
  logic                   sync_q, sync_n;
  logic                   busy_q;

  logic [AW-1:0] last_cfg;
  logic [AW-1:0] addr_ext;
  logic [AW-1:0] next_addr;
  logic          start;
  logic          load_byte;
  logic          bit_next;
  logic          fetch;
  logic          more;
  logic          high_done;
  logic          bit_done;

  anton_neopixel_bit_encoder #(
    .CYCLES_BIT (CYCLES_BIT),
    .CYCLES_T0H (CYCLES_T0H),
    .CYCLES_T1H (CYCLES_T1H)
  ) u_bit_encoder (
    .busClk   (busClk),
    .busReset (busReset),
    .bitValue (bit_next),
    .start    (start),
    .neoData  (neoData),
    .highDone (high_done),
    .bitDone  (bit_done)
  );

  // Frame configuration candidate, captured only at frame start.
  always_comb begin
    last_cfg = BUF_END;
    if (reg_ctrl_limit && (AW'(reg_max) < BUF_END)) begin
      last_cfg = AW'(reg_max);
    end
  end

  // Address of the following byte, skipping slot byte 3 in 32-bit mode.
  always_comb begin
    addr_ext  = AW'(addr_q);
    next_addr = addr_ext + AW'(1);
    if (mode32_q && (next_addr[1:0] == 2'b11)) begin
      next_addr = addr_ext + AW'(2);
    end
  end

  assign more = (bit_idx_q != 3'd0) || !last_byte_q;

  always_ff @(posedge busClk) begin
    if (busReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (reg_ctrl_run) state_n = HIGH;
      HIGH:    if (high_done)    state_n = LOW;
      LOW:     if (bit_done)     state_n = more ? HIGH : LATCH;
      LATCH:   if (latch_q == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    start     = ((state_q == IDLE) && reg_ctrl_run) ||
                ((state_q == LOW) && bit_done && more);
    load_byte = (state_q == IDLE) || (bit_idx_q == 3'd0);
    bit_next  = load_byte ? pixelData[7] : shift_q[6];
    // The next address is settled at the start of the last bit's low phase,
    // so pixelData is stable well before it is loaded at bitDone.
    fetch     = (state_q == HIGH) && high_done && (bit_idx_q == 3'd0);

    latch_n = latch_q;
    if ((state_q == LOW) && (state_n == LATCH)) begin
      latch_n = LW'(CYCLES_RESET - 1);
    end else if ((state_q == LATCH) && (latch_q != '0)) begin
      latch_n = latch_q - 1'b1;
    end
    sync_n = (state_n == LATCH) && (latch_n == '0);
  end

  always_ff @(posedge busClk) begin
    if (busReset) begin
      addr_q      <= '0;
      last_q      <= '0;
      mode32_q    <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      last_byte_q <= 1'b0;
      latch_q     <= '0;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      latch_q <= latch_n;
      sync_q  <= sync_n;
      busy_q  <= (state_n != IDLE);

      if ((state_q == IDLE) && reg_ctrl_run) begin
        last_q      <= last_cfg;
        mode32_q    <= reg_ctrl_32bit;
        last_byte_q <= 1'b0;
      end

      if (start) begin
        if (load_byte) begin
          shift_q   <= pixelData[6:0];
          bit_idx_q <= 3'd7;
        end else begin
          shift_q   <= {shift_q[5:0], 1'b0};
          bit_idx_q <= bit_idx_q - 3'd1;
        end
      end

      if (fetch) begin
        if (next_addr > last_q) begin
          last_byte_q <= 1'b1;
        end else begin
          addr_q <= BUFFER_BITS'(next_addr);
        end
      end

      // Park on byte 0 so the next frame start sees its data immediately.
      if ((state_q == LATCH) && (state_n == IDLE)) begin
        addr_q <= '0;
      end
    end
  end

  assign pixelAddr      = addr_q;
  assign stream_sync_of = sync_q;
  assign state          = busy_q;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
module tb_anton_neopixel_stream;

  localparam int BEND   = 15;
  localparam int T_BIT  = 25;
  localparam int T_0H   = 8;
  localparam int T_1H   = 16;
  localparam int T_RST  = 1000;
  localparam int BUDGET = 6000;

  logic        clk;
  logic        rst;
  logic [3:0]  pixel_addr;
  logic [7:0]  pixel_data;
  logic [12:0] reg_max;
  logic        limit;
  logic        run;
  logic        m32;
  logic        neo;
  logic        sync;
  logic        st;

  logic [7:0] buf_mem [0:BEND];
  assign pixel_data = buf_mem[pixel_addr];

  anton_neopixel_stream #(
    .BUFFER_END   (BEND),
    .CYCLES_BIT   (T_BIT),
    .CYCLES_T0H   (T_0H),
    .CYCLES_T1H   (T_1H),
    .CYCLES_RESET (T_RST)
  ) dut (
    .busClk         (clk),
    .busReset       (rst),
    .pixelAddr      (pixel_addr),
    .pixelData      (pixel_data),
    .reg_max        (reg_max),
    .reg_ctrl_limit (limit),
    .reg_ctrl_run   (run),
    .reg_ctrl_32bit (m32),
    .neoData        (neo),
    .stream_sync_of (sync),
    .state          (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    string       name;
    bit          limit;
    logic [12:0] max;
    bit          m32;
    int          nbytes;
  } vec_t;

  vec_t vecs [9];

  int hi_q [$];
  int per_q [$];
  int addr_q [$];
  int sync_cnt, t_first, t_sync, t_idle;
  bit timed_out;

  function automatic int exp_addr(input int k, input bit mode32);
    return mode32 ? (k / 3) * 4 + (k % 3) : k;
  endfunction

  // Called at a negedge with the configuration already applied.
  task automatic capture(input bit keep_run, input int chg_rise);
    int  last_rise;
    int  nrise;
    bit  prev_nd;
    bit  seen;
    hi_q.delete(); per_q.delete(); addr_q.delete();
    sync_cnt = 0; t_first = -1; t_sync = -1; t_idle = -1; timed_out = 1;
    last_rise = 0; nrise = 0; prev_nd = 0; seen = 0;
    run = 1'b1;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (neo && !prev_nd) begin
        if (nrise > 0) per_q.push_back(cyc - last_rise);
        else t_first = cyc;
        addr_q.push_back(int'(pixel_addr));
        last_rise = cyc;
        nrise++;
        if (nrise == 1 && !keep_run) run = 1'b0;
        if (nrise == chg_rise) begin
          run = 1'b0; reg_max = 13'd0; limit = 1'b0; m32 = 1'b1;
        end
      end
      if (!neo && prev_nd) hi_q.push_back(cyc - last_rise);
      prev_nd = neo;
      if (sync) begin sync_cnt++; t_sync = cyc; end
      if (st) seen = 1;
      else if (seen) begin t_idle = cyc; timed_out = 0; break; end
    end
  endtask

  task automatic check_frame(input string name, input int nbytes, input bit mode32);
    int bad_per, bad_hi, bad_data, bad_addr;
    logic [7:0] b;
    chk({name, " timeout"}, timed_out, 0);
    chk({name, " start latency"}, t_first, 1);
    chk({name, " bits"}, hi_q.size(), nbytes * 8);
    chk({name, " frame length"}, t_idle - t_first, nbytes * 8 * T_BIT + T_RST);
    chk({name, " sync count"}, sync_cnt, 1);
    chk({name, " sync position"}, t_sync, t_idle - 1);
    bad_per = 0;
    foreach (per_q[i]) if (per_q[i] != T_BIT) bad_per++;
    chk({name, " bit periods"}, bad_per, 0);
    bad_hi = 0; bad_data = 0; bad_addr = 0;
    foreach (hi_q[i]) if (hi_q[i] != T_0H && hi_q[i] != T_1H) bad_hi++;
    chk({name, " high widths"}, bad_hi, 0);
    for (int k = 0; k < nbytes; k++) begin
      if (8 * k + 7 < hi_q.size()) begin
        b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], (hi_q[8 * k + j] == T_1H)};
        if (b != buf_mem[exp_addr(k, mode32)]) bad_data++;
      end else begin
        bad_data++;
      end
      if (8 * k < addr_q.size()) begin
        if (addr_q[8 * k] != exp_addr(k, mode32)) bad_addr++;
      end else begin
        bad_addr++;
      end
    end
    chk({name, " data bytes"}, bad_data, 0);
    chk({name, " address sequence"}, bad_addr, 0);
  endtask

  initial begin
    int cnt;
    bit hit;
    vecs[0] = '{"single byte",   1'b1, 13'd0,      1'b0, 1};
    vecs[1] = '{"32bit skip",    1'b1, 13'd7,      1'b1, 6};
    vecs[2] = '{"limit clamp",   1'b1, 13'h1FFF,   1'b0, 16};
    vecs[3] = '{"no limit",      1'b0, 13'd3,      1'b0, 16};
    vecs[4] = '{"32bit last=3",  1'b1, 13'd3,      1'b1, 3};
    vecs[5] = '{"8bit last=3",   1'b1, 13'd3,      1'b0, 4};
    vecs[6] = '{"32bit full",    1'b0, 13'd0,      1'b1, 12};
    vecs[7] = '{"32bit last=4",  1'b1, 13'd4,      1'b1, 4};
    vecs[8] = '{"32bit last=15", 1'b1, 13'd15,     1'b1, 12};

    for (int i = 0; i <= BEND; i++) buf_mem[i] = 8'(i * 37 + 8'h5A);
    buf_mem[0] = 8'hA5;

    rst = 1'b1; run = 1'b0; limit = 1'b0; m32 = 1'b0; reg_max = 13'd0;
    repeat (3) @(negedge clk);
    chk("reset neoData", neo, 0);
    chk("reset state", st, 0);
    chk("reset sync", sync, 0);
    chk("reset pixelAddr", pixel_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: explicit high-time pattern.
    limit = 1'b1; reg_max = 13'd0; m32 = 1'b0;
    @(negedge clk);
    capture(1'b0, 0);
    begin
      int exp_hi [8] = '{16, 8, 16, 8, 8, 16, 8, 16};
      int bad = 0;
      for (int j = 0; j < 8; j++)
        if (j >= hi_q.size() || hi_q[j] != exp_hi[j]) bad++;
      chk("A5 high pattern", bad, 0);
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      limit = vecs[i].limit; reg_max = vecs[i].max; m32 = vecs[i].m32;
      @(negedge clk);
      capture(1'b0, 0);
      run = 1'b0;
      check_frame(vecs[i].name, vecs[i].nbytes, vecs[i].m32);
      repeat (3) @(negedge clk);
      chk({vecs[i].name, " stays idle"}, st, 0);
    end

    // Loop mode: run held through the sync pulse.
    limit = 1'b1; reg_max = 13'd1; m32 = 1'b0;
    @(negedge clk);
    capture(1'b1, 0);
    check_frame("loop frame1", 2, 1'b0);
    chk("loop idle neoData", neo, 0);
    @(negedge clk);
    chk("loop restart neoData", neo, 1);
    chk("loop restart state", st, 1);
    chk("loop restart vs sync", t_idle + 1 - t_sync, 2);
    run = 1'b0;
    cnt = 0; hit = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (sync) cnt++;
      if (!st) begin hit = 1; break; end
    end
    chk("loop frame2 ended", hit, 1);
    chk("loop frame2 sync", cnt, 1);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (st || neo) cnt++;
    end
    chk("loop stop idle", cnt, 0);

    // Run dropped and configuration flipped during byte 2.
    limit = 1'b1; reg_max = 13'd3; m32 = 1'b0;
    @(negedge clk);
    capture(1'b1, 17);
    check_frame("mid-frame change", 4, 1'b0);
    repeat (20) @(negedge clk);
    chk("mid-frame stays idle", st, 0);

    // Reset during a HIGH phase.
    limit = 1'b0; reg_max = 13'd0; m32 = 1'b0;
    @(negedge clk);
    run = 1'b1;
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (neo && pixel_addr == 4'd2) begin hit = 1; break; end
    end
    chk("reset test reached high", hit, 1);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    chk("mid reset neoData", neo, 0);
    chk("mid reset state", st, 0);
    chk("mid reset pixelAddr", pixel_addr, 0);
    chk("mid reset sync", sync, 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (sync || neo || st) cnt++;
    end
    chk("after reset quiet", cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_stream.md
# anton_neopixel_stream

Serial bit-stream encoder sitting directly downstream of the NeoPixel register block. It fetches bytes from the front (non-selected) pixel buffer and drives the single-wire WS2812 waveform. It appends the low reset/latch period and then pulses `stream_sync_of` so the register block can clear or keep `reg_ctrl_run` (loop mode). It also reports the busy `state` that the register block exposes at control address 3.

## Interface
- `BUFFER_END`, `BUFFER_END_DEFAULT`: index of the last pixel byte; `BUFFER_BITS = CLOG2(BUFFER_END+1)`.
- `CYCLES_BIT`, 25: clocks per data bit (1.25 µs at 20 MHz).
- `CYCLES_T0H`, 8: high clocks for a 0 bit.
- `CYCLES_T1H`, 16: high clocks for a 1 bit.
- `CYCLES_RESET`, 1000: low latch clocks after the last bit (50 µs).
- `busClk` in 1: single clock (already decided).
- `busReset` in 1: synchronous, active-high reset (already decided).
- `pixelAddr` out BUFFER_BITS: byte index into the front buffer.
- `pixelData` in 8: front-buffer byte at `pixelAddr`, valid combinationally in the same cycle.
- `reg_max` in 13: last byte index when limit is enabled.
- `reg_ctrl_limit` in 1: use `reg_max` instead of `BUFFER_END`.
- `reg_ctrl_run` in 1: request a frame.
- `reg_ctrl_32bit` in 1: 4-byte pixel slots; byte 3 of each slot is skipped.
- `neoData` out 1: NeoPixel data line.
- `stream_sync_of` out 1: one-cycle pulse at the end of the latch period.
- `state` out 1: 1 from frame start until the latch period ends, 0 in IDLE.

## Operation
- **States:**
  - IDLE: `neoData` = 0, `state` = 0.
  - HIGH: bit high phase.
  - LOW: bit low phase.
  - LATCH: `neoData` = 0, `state` = 1.
- **Frame start:**
  - `reg_ctrl_run` is sampled only in IDLE.
  - When it is 1, latch the configuration:
    - `last = reg_ctrl_limit ? min(reg_max, BUFFER_END) : BUFFER_END`
    - `mode32 = reg_ctrl_32bit`
  - Set the address to 0, load `pixelData` into the shift register, set the bit index to 7, and go to HIGH.
  - Changes to `reg_max`, `reg_ctrl_limit` or `reg_ctrl_32bit` during a frame have no effect until the next frame.
- **Bit encoding:**
  - MSB first.
  - HIGH lasts `CYCLES_T1H` if the current bit is 1, else `CYCLES_T0H`.
  - LOW lasts the remainder, so HIGH + LOW = `CYCLES_BIT` exactly.
  - `neoData` is 1 only in HIGH.
- **Byte advance:**
  - After bit 0 of a byte, `next = addr + 1`.
  - If `mode32` and `next[1:0] == 3`, then `next = addr + 2`.
  - If `next > last`, go to LATCH.
  - Otherwise set `pixelAddr = next`, load `pixelData` in the cycle after the address update, and continue with no gap between bits.
  - The address comparison is 14 bits wide, so no wrap-around.
- **32-bit boundary:** when `last[1:0] == 3`, that byte is never sent.
- **LATCH:**
  - Lasts `CYCLES_RESET` clocks.
  - `stream_sync_of` = 1 on the final LATCH clock only.
  - Then go to IDLE.
- **Run dropped mid-frame:** the frame completes, including LATCH and the sync pulse; the stream is never truncated.
- **Loop mode:** the register block sets `run <= loop` on the sync pulse. If run is still 1, the next frame starts on the first IDLE cycle.
- **Reset:**
  - `busReset` in any state forces, on the next edge: IDLE, `neoData` = 0, `state` = 0, `stream_sync_of` = 0, `pixelAddr` = 0, counters = 0.
  - The waveform is cut immediately.

## Timing
- **Start latency:** first IDLE cycle with `run` = 1 leads to HIGH on the next edge, so `neoData` and `state` rise one clock after run is seen.
- **Frame duration:** `nbytes*8*CYCLES_BIT + CYCLES_RESET` clocks from the first `neoData` rise to the return to IDLE.
- **Minimum frame:** one byte when `last = 0`.
- **Back-to-back frames:**
  - With loop, IDLE lasts exactly 1 clock between frames.
  - Minimum `neoData` low between frames is `CYCLES_RESET + 1` clocks, plus the final bit's low time.
- **Byte fetch:** `pixelData` is sampled while the final bit of the previous byte is in LOW. This requires `CYCLES_BIT - CYCLES_T1H >= 2`.
- **Registered outputs:** `neoData`, `state` and `stream_sync_of` are all registered, with no combinational path from inputs.

## Structure
- **Shared package `anton_neopixel_pkg`:**
  - FSM state typedef `{IDLE, HIGH, LOW, LATCH}`.
  - Default timing constants (`CYCLES_*`) for 20 MHz.
  - Keep `BUFFER_END_DEFAULT`/`CLOG2` in `anton_common.vh`.
- **Sub-module `anton_neopixel_bit_encoder`:**
  - Inputs: `bitValue`, `start`.
  - Outputs: `neoData`, `bitDone`.
  - Owns the HIGH/LOW phase counter.
  - The parent owns the byte/address sequencing and LATCH.

## Test plan
- **Single byte:** limit=1, max=0, buffer[0]=0xA5, run=1. Expect:
  - 8 bits with high times 16,8,16,8,8,16,8,16 and each bit 25 clocks.
  - 1000 low clocks, `stream_sync_of` one clock, `state` back to 0.
- **32-bit skip:** mode32=1, limit=1, max=7. Expect:
  - `pixelAddr` sequence 0,1,2,4,5,6.
  - 6 bytes = 1200 bit clocks.
- **Limit clamp:** max=0x1FFF, limit=1. Expect the frame to end after `BUFFER_END`.
- **Loop:** run held 1 through the sync. Expect:
  - Second frame `neoData` rises exactly 2 clocks after the `stream_sync_of` cycle.
  - With run=0 at sync, stay IDLE.
- **Mid-frame change:** drop run and flip max during byte 2. Expect the frame to complete with the original length and the sync still to pulse.
- **Reset:** assert `busReset` during a HIGH phase. Expect the next edge to give `neoData` = 0, `state` = 0, `pixelAddr` = 0, and no sync pulse.
